vga_timing_gen: RTL and testbench

Generates 640x480@60 Hz VGA timing for the sprite-demo display path. It divides the 100 MHz board clock into a 25 MHz pixel clock and runs the horizontal and vertical pixel counters. It produces the sync, bright and frame-tick signals that drive the background and sprite controllers. It also provides sync/bright copies delayed by a configurable number of pixels, to line up with sprite ROMs that have registered outputs.

---
 rtl/vga_timing_gen.sv | 126 ++++++++++++
 tb/tb_vga_timing_gen.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing: divides the 100 MHz board clock into a 25 MHz pixel clock,
// runs the pixel/line counters and derives sync, bright, frame-tick and delayed copies.
module vga_timing_gen #(
    parameter int H_TOTAL    = 800,
    parameter int V_TOTAL    = 525,
    parameter int H_SYNC     = 96,
    parameter int V_SYNC     = 2,
    parameter int H_START    = 144,
    parameter int H_END      = 783,
    parameter int V_START    = 35,
    parameter int V_END      = 514,
    parameter int PIPE_DELAY = 1
) (
    input  logic       ClkPort,
    input  logic       rst,
    output logic       clk,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       frame_tick,
    output logic       hSync_d,
    output logic       vSync_d,
    output logic       bright_d
);
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_L  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_L  = 10'(V_SYNC);
    localparam logic [9:0] H_START_L = 10'(H_START);
    localparam logic [9:0] H_END_L   = 10'(H_END);
    localparam logic [9:0] V_START_L = 10'(V_START);
    localparam logic [9:0] V_END_L   = 10'(V_END);

    logic [1:0] div_reg, div_next;
    logic       clk_reg;
    logic [9:0] h_reg, h_next, v_reg, v_next;
    logic       step, wrap_frame;
    logic       hsync_reg, vsync_reg, bright_reg, frame_tick_reg;
    logic       hsync_next, vsync_next, bright_next;
    logic [2:0] sync_now;

    always_comb begin
        div_next   = div_reg + 2'd1;
        step       = (div_reg == 2'd3);
        h_next     = h_reg;
        v_next     = v_reg;
        wrap_frame = 1'b0;
        if (step) begin
            // Out-of-range counts fall through the >= tests and return to zero.
            if (h_reg >= H_LAST) begin
                h_next = '0;
                if (v_reg >= V_LAST) begin
                    v_next     = '0;
                    wrap_frame = (h_reg == H_LAST) && (v_reg == V_LAST);
                end else begin
                    v_next = v_reg + 10'd1;
                end
            end else begin
                h_next = h_reg + 10'd1;
                if (v_reg > V_LAST) begin
                    v_next = '0;
                end
            end
        end
        hsync_next  = (h_next >= H_SYNC_L);
        vsync_next  = (v_next >= V_SYNC_L);
        bright_next = (h_next >= H_START_L) && (h_next <= H_END_L) &&
                      (v_next >= V_START_L) && (v_next <= V_END_L);
    end

    always_ff @(posedge ClkPort) begin
        if (rst) begin
            div_reg        <= '0;
            clk_reg        <= 1'b0;
            h_reg          <= '0;
            v_reg          <= '0;
            hsync_reg      <= 1'b0;
            vsync_reg      <= 1'b0;
            bright_reg     <= 1'b0;
            frame_tick_reg <= 1'b0;
        end else begin
            div_reg        <= div_next;
            clk_reg        <= div_next[1];
            h_reg          <= h_next;
            v_reg          <= v_next;
            hsync_reg      <= hsync_next;
            vsync_reg      <= vsync_next;
            bright_reg     <= bright_next;
            frame_tick_reg <= wrap_frame;
        end
    end

    assign clk        = clk_reg;
    assign hCount     = h_reg;
    assign vCount     = v_reg;
    assign hSync      = hsync_reg;
    assign vSync      = vsync_reg;
    assign bright     = bright_reg;
    assign frame_tick = frame_tick_reg;
    assign sync_now   = {hsync_reg, vsync_reg, bright_reg};

    genvar gi;
    generate
        if (PIPE_DELAY == 0) begin : g_nodelay
            assign {hSync_d, vSync_d, bright_d} = sync_now;
        end else begin : g_delay
            logic [2:0] stage_reg [PIPE_DELAY];
            for (gi = 0; gi < PIPE_DELAY; gi++) begin : g_stage
                if (gi == 0) begin : g_first
                    always_ff @(posedge ClkPort) begin
                        if (rst)       stage_reg[0] <= '0;
                        else if (step) stage_reg[0] <= sync_now;
                    end
                end else begin : g_chain
                    always_ff @(posedge ClkPort) begin
                        if (rst)       stage_reg[gi] <= '0;
                        else if (step) stage_reg[gi] <= stage_reg[gi-1];
                    end
                end
            end
            assign {hSync_d, vSync_d, bright_d} = stage_reg[PIPE_DELAY-1];
        end
    endgenerate
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one full-size instance plus two reduced-geometry instances,
// every output checked each cycle against a pixel-index model derived from elapsed edges.
module tb_vga_timing_gen;
    typedef struct {
        int ht, vt, hs, vs, hst, he, vst, ve, d;
    } cfg_t;

    typedef struct packed {
        logic       clk;
        logic [9:0] h;
        logic [9:0] v;
        logic       hs, vs, br, ft, hsd, vsd, brd;
    } obs_t;

    cfg_t cfg_a = '{800, 525, 96, 2, 144, 783, 35, 514, 1};
    cfg_t cfg_b = '{40, 12, 6, 2, 9, 33, 3, 9, 2};
    cfg_t cfg_c = '{40, 12, 6, 2, 9, 33, 3, 9, 0};

    logic ClkPort = 1'b0;
    always #5 ClkPort = ~ClkPort;

    logic rst_a, rst_b;
    logic clk_a, hs_a, vs_a, br_a, ft_a, hsd_a, vsd_a, brd_a;
    logic clk_b, hs_b, vs_b, br_b, ft_b, hsd_b, vsd_b, brd_b;
    logic clk_c, hs_c, vs_c, br_c, ft_c, hsd_c, vsd_c, brd_c;
    logic [9:0] h_a, v_a, h_b, v_b, h_c, v_c;

    vga_timing_gen #(.PIPE_DELAY(1)) dut_a (
        .ClkPort(ClkPort), .rst(rst_a), .clk(clk_a), .hCount(h_a), .vCount(v_a),
        .hSync(hs_a), .vSync(vs_a), .bright(br_a), .frame_tick(ft_a),
        .hSync_d(hsd_a), .vSync_d(vsd_a), .bright_d(brd_a));

    vga_timing_gen #(.H_TOTAL(40), .V_TOTAL(12), .H_SYNC(6), .V_SYNC(2), .H_START(9),
                     .H_END(33), .V_START(3), .V_END(9), .PIPE_DELAY(2)) dut_b (
        .ClkPort(ClkPort), .rst(rst_b), .clk(clk_b), .hCount(h_b), .vCount(v_b),
        .hSync(hs_b), .vSync(vs_b), .bright(br_b), .frame_tick(ft_b),
        .hSync_d(hsd_b), .vSync_d(vsd_b), .bright_d(brd_b));

    vga_timing_gen #(.H_TOTAL(40), .V_TOTAL(12), .H_SYNC(6), .V_SYNC(2), .H_START(9),
                     .H_END(33), .V_START(3), .V_END(9), .PIPE_DELAY(0)) dut_c (
        .ClkPort(ClkPort), .rst(rst_b), .clk(clk_c), .hCount(h_c), .vCount(v_c),
        .hSync(hs_c), .vSync(vs_c), .bright(br_c), .frame_tick(ft_c),
        .hSync_d(hsd_c), .vSync_d(vsd_c), .bright_d(brd_c));

    int total, bad;
    int k_a, k_b;
    int cyc;
    int ft1_cyc, ft2_cyc, ft1_k;
    int pat [8] = '{0, 1, 1, 0, 0, 1, 1, 0};

    // Sync/bright for a given pixel index, straight from the window definitions.
    function automatic logic [2:0] syncs(input int p, input cfg_t c);
        int h, v;
        h = p % c.ht;
        v = (p / c.ht) % c.vt;
        return {h >= c.hs, v >= c.vs, (h >= c.hst) && (h <= c.he) && (v >= c.vst) && (v <= c.ve)};
    endfunction

    // k = ClkPort edges since the last edge that sampled reset high; p = pixel steps taken.
    function automatic obs_t model(input int k, input cfg_t c);
        obs_t e;
        int p;
        p = k / 4;
        e.clk = ((k % 4) >= 2);
        e.h   = 10'(p % c.ht);
        e.v   = 10'((p / c.ht) % c.vt);
        {e.hs, e.vs, e.br} = syncs(p, c);
        e.ft  = (k > 0) && (k % 4 == 0) && (p % (c.ht * c.vt) == 0);
        if (p >= c.d) {e.hsd, e.vsd, e.brd} = syncs(p - c.d, c);
        else          {e.hsd, e.vsd, e.brd} = 3'b000;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_dut(input string id, input int k, input cfg_t c, input obs_t o);
        obs_t e;
        e = model(k, c);
        chk({id, ".clk"},        32'(o.clk), 32'(e.clk));
        chk({id, ".hCount"},     32'(o.h),   32'(e.h));
        chk({id, ".vCount"},     32'(o.v),   32'(e.v));
        chk({id, ".hSync"},      32'(o.hs),  32'(e.hs));
        chk({id, ".vSync"},      32'(o.vs),  32'(e.vs));
        chk({id, ".bright"},     32'(o.br),  32'(e.br));
        chk({id, ".frame_tick"}, 32'(o.ft),  32'(e.ft));
        chk({id, ".hSync_d"},    32'(o.hsd), 32'(e.hsd));
        chk({id, ".vSync_d"},    32'(o.vsd), 32'(e.vsd));
        chk({id, ".bright_d"},   32'(o.brd), 32'(e.brd));
    endtask

    task automatic tick();
        @(posedge ClkPort);
        cyc++;
        k_a = rst_a ? 0 : ((k_a < 0) ? -1 : k_a + 1);
        k_b = rst_b ? 0 : ((k_b < 0) ? -1 : k_b + 1);
        @(negedge ClkPort);
        if (k_a >= 0) check_dut("a", k_a, cfg_a, {clk_a, h_a, v_a, hs_a, vs_a, br_a, ft_a, hsd_a, vsd_a, brd_a});
        if (k_b >= 0) begin
            check_dut("b", k_b, cfg_b, {clk_b, h_b, v_b, hs_b, vs_b, br_b, ft_b, hsd_b, vsd_b, brd_b});
            check_dut("c", k_b, cfg_c, {clk_c, h_c, v_c, hs_c, vs_c, br_c, ft_c, hsd_c, vsd_c, brd_c});
        end
        if (ft_b === 1'b1) begin
            if (ft1_cyc < 0) begin
                ft1_cyc = cyc;
                ft1_k   = k_b;
            end else if (ft2_cyc < 0) begin
                ft2_cyc = cyc;
            end
        end
    endtask

    initial begin
        int found, hold;
        total = 0; bad = 0; cyc = 0;
        k_a = -1; k_b = -1;
        ft1_cyc = -1; ft2_cyc = -1; ft1_k = -1;
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (3) tick();
        rst_a = 1'b0; rst_b = 1'b0;

        // Divider pattern and first pixel step after release.
        for (int n = 0; n < 8; n++) begin
            tick();
            chk("a.clk_pattern", 32'(clk_a), 32'(pat[n]));
            if (n == 3) chk("a.first_step_h", 32'(h_a), 32'd1);
        end

        // Full-size instance to (799,10), then the line wrap.
        while (k_a < 4 * (800 * 10 + 799) && bad < 50) tick();
        chk("a.pre_wrap_h", 32'(h_a), 32'd799);
        chk("a.pre_wrap_v", 32'(v_a), 32'd10);
        repeat (4) tick();
        chk("a.line_wrap_h", 32'(h_a), 32'd0);
        chk("a.line_wrap_v", 32'(v_a), 32'd11);
        chk("a.line_wrap_ft", 32'(ft_a), 32'd0);

        // Reduced-geometry frame tick: first pulse and spacing.
        chk("b.first_tick_k", 32'(ft1_k), 32'(4 * 40 * 12));
        chk("b.tick_spacing", 32'(ft2_cyc - ft1_cyc), 32'(4 * 40 * 12));

        // Directed mid-frame reset at (20,6).
        found = 0;
        for (int n = 0; n < 2000 && found == 0; n++) begin
            tick();
            if (h_b == 10'd20 && v_b == 10'd6) found = 1;
        end
        chk("b.reach_mid", 32'(found), 32'd1);
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        chk("b.mid_rst_h", 32'(h_b), 32'd0);
        chk("b.mid_rst_v", 32'(v_b), 32'd0);
        chk("b.mid_rst_sync", 32'({hs_b, vs_b, br_b, ft_b, clk_b}), 32'd0);
        chk("b.mid_rst_d", 32'({hsd_b, vsd_b, brd_b}), 32'd0);

        // Randomly placed resets of random length on the reduced instances.
        for (int r = 0; r < 6 && bad < 50; r++) begin
            repeat ($urandom_range(50, 2500)) tick();
            hold = $urandom_range(1, 3);
            rst_b = 1'b1;
            repeat (hold) tick();
            rst_b = 1'b0;
        end
        repeat (2100) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
